lcd_score_scheduler: RTL and testbench

//  Match-level controller for the LCD command sequencer. Queues point pulses from the game logic and keeps game/set/match counts.

---
 rtl/lcd_score_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_lcd_score_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_score_scheduler.sv
// Match-level score keeper for the LCD command sequencer: queues point pulses,
// tracks game/set/match counts and issues one op/data command per event.
module lcd_score_scheduler #(
   parameter int GAMES_PER_SET = 6,
   parameter int SETS_TO_WIN   = 2,
   parameter int SET_COL_BASE  = 0,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p1_point,
   input  logic        p2_point,
   input  logic        new_match,
   input  logic        cmd_ready,
   output logic [3:0]  op,
   output logic [31:0] data,
   output logic        busy,
   output logic        match_over,
   output logic [1:0]  winner,
   output logic        drop_sticky
);

   localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FIFO_FULL = FIFO_DEPTH[AW:0];
   localparam logic [3:0]  G_WIN     = GAMES_PER_SET[3:0];
   localparam logic [1:0]  S_WIN     = SETS_TO_WIN[1:0];
   localparam logic [7:0]  COL_BASE  = SET_COL_BASE[7:0];
   localparam logic [3:0]  OP_NONE   = 4'd15;

   typedef enum logic [2:0] {INIT, IDLE, CALC, ISSUE, ACK, DONE, OVER} state_t;

   state_t                state;
   logic [FIFO_DEPTH-1:0] fifo_mem;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [3:0]            g1;
   logic [3:0]            g2;
   logic [1:0]            s1;
   logic [1:0]            s2;
   logic [2:0]            set_idx;
   logic                  ev_p2;
   logic                  match_end;
   logic                  nm_pend;

   logic handshake, capture, push_req, pop, full, push_ok, drop, clear;

   always_comb begin
      handshake = (state == ISSUE) || (state == ACK) || (state == DONE);
      capture   = (state != INIT) && (state != OVER) && !new_match;
      push_req  = capture && (p1_point || p2_point);
      pop       = (state == IDLE) && (count != '0);
      full      = (count == FIFO_FULL);
      push_ok   = push_req && (!full || pop);
      drop      = (capture && p1_point && p2_point) || (push_req && !push_ok);
      // A new_match seen mid-handshake is deferred until the sequencer finishes.
      clear     = (new_match && !handshake) ||
                  ((state == DONE) && cmd_ready && (nm_pend || new_match));
   end

   logic [3:0]  g_win, g1_fin, g2_fin;
   logic [1:0]  s_win, s_lose;
   logic [7:0]  set_col;
   logic        set_closes, match_closes;
   logic [3:0]  calc_op;
   logic [31:0] calc_data;

   always_comb begin
      g_win        = (ev_p2 ? g2 : g1) + 4'd1;
      s_win        = (ev_p2 ? s2 : s1) + 2'd1;
      s_lose       = ev_p2 ? s1 : s2;
      g1_fin       = ev_p2 ? g1 : g_win;
      g2_fin       = ev_p2 ? g_win : g2;
      set_col      = COL_BASE + {4'b0, set_idx, 1'b0};
      set_closes   = (g_win >= G_WIN);
      match_closes = (s_win >= S_WIN);
      calc_op      = ev_p2 ? 4'd2 : 4'd1;
      calc_data    = {28'b0, g_win};
      if (set_closes && !match_closes) begin
         calc_op   = ev_p2 ? 4'd4 : 4'd3;
         calc_data = {set_col, 6'b0, s_win, 4'b0, g2_fin, 4'b0, g1_fin};
      end else if (set_closes) begin
         calc_op   = ev_p2 ? 4'd6 : 4'd5;
         calc_data = {set_col, 6'b0, s_lose, 4'b0, g2_fin, 4'b0, g1_fin};
      end
   end

   // Point-event queue; entries hold 1 for a player-2 point.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= p2_point && !p1_point;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         drop_sticky <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
         if (drop) drop_sticky <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         op        <= OP_NONE;
         data      <= '0;
         g1        <= '0;
         g2        <= '0;
         s1        <= '0;
         s2        <= '0;
         set_idx   <= '0;
         winner    <= 2'b00;
         match_end <= 1'b0;
         nm_pend   <= 1'b0;
         ev_p2     <= 1'b0;
      end else if (clear) begin
         state     <= INIT;
         g1        <= '0;
         g2        <= '0;
         s1        <= '0;
         s2        <= '0;
         set_idx   <= '0;
         winner    <= 2'b00;
         match_end <= 1'b0;
         nm_pend   <= 1'b0;
      end else begin
         if (handshake && new_match) nm_pend <= 1'b1;
         case (state)
            INIT: begin
               op    <= 4'd0;
               data  <= '0;
               state <= ISSUE;
            end
            IDLE: begin
               if (pop) begin
                  ev_p2 <= fifo_mem[rd_ptr];
                  state <= CALC;
               end
            end
            CALC: begin
               op   <= calc_op;
               data <= calc_data;
               if (ev_p2) g2 <= g_win;
               else       g1 <= g_win;
               if (set_closes) begin
                  if (ev_p2) s2 <= s_win;
                  else       s1 <= s_win;
                  if (!match_closes) begin
                     g1      <= '0;
                     g2      <= '0;
                     set_idx <= set_idx + 3'd1;
                  end else begin
                     winner    <= ev_p2 ? 2'b10 : 2'b01;
                     match_end <= 1'b1;
                  end
               end
               state <= ISSUE;
            end
            ISSUE: if (cmd_ready) state <= ACK;
            ACK: begin
               if (!cmd_ready) begin
                  op    <= OP_NONE;
                  state <= DONE;
               end
            end
            DONE: if (cmd_ready) state <= match_end ? OVER : IDLE;
            OVER: state <= OVER;
            default: state <= INIT;
         endcase
      end
   end

   assign busy       = !((state == IDLE) || (state == OVER)) || (count != '0);
   assign match_over = (state == OVER);

endmodule

// File: tb/tb_lcd_score_scheduler.sv
// Directed bench for lcd_score_scheduler: sequencer model on cmd_ready, a
// score model producing expected commands, and literal spot checks.
module tb_lcd_score_scheduler;

   localparam int GPS   = 6;
   localparam int STW   = 2;
   localparam int COLB  = 0;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p1_point = 1'b0;
   logic        p2_point = 1'b0;
   logic        new_match = 1'b0;
   logic        cmd_ready;
   logic [3:0]  op;
   logic [31:0] data;
   logic        busy;
   logic        match_over;
   logic [1:0]  winner;
   logic        drop_sticky;

   lcd_score_scheduler #(
      .GAMES_PER_SET(GPS),
      .SETS_TO_WIN  (STW),
      .SET_COL_BASE (COLB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p1_point   (p1_point),
      .p2_point   (p2_point),
      .new_match  (new_match),
      .cmd_ready  (cmd_ready),
      .op         (op),
      .data       (data),
      .busy       (busy),
      .match_over (match_over),
      .winner     (winner),
      .drop_sticky(drop_sticky)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   txn_t        cur_t;
   logic [3:0]  log_op[$];
   logic [31:0] log_data[$];

   int m_g1, m_g2, m_s1, m_s2, m_set, m_win;
   bit m_over;

   int seq_busy = 30;
   bit seq_hold = 1'b0;
   int seen = 0;
   int bcnt = 0;
   bit in_busy = 1'b0;

   int base_n;
   int w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic chk_log(input string name, input int idx, input logic [3:0] eop, input logic [31:0] edata);
      if (idx < 0 || idx >= log_op.size()) begin
         checks++;
         errors++;
         $display("FAIL %s: no accepted command #%0d, expected op %0d data %0h", name, idx, eop, edata);
      end else begin
         chk({name, "_op"}, 32'(log_op[idx]), 32'(eop));
         chk({name, "_data"}, log_data[idx], edata);
      end
   endtask

   task automatic push_exp(input int o, input int d);
      txn_t t;
      t.op   = 4'(o);
      t.data = 32'(d);
      exp_q.push_back(t);
   endtask

   task automatic model_new_match();
      m_g1 = 0; m_g2 = 0; m_s1 = 0; m_s2 = 0; m_set = 0; m_win = 0; m_over = 1'b0;
      push_exp(0, 0);
   endtask

   // Scoring rules: each kept point yields exactly one expected command.
   task automatic model_point(input bit is_p2);
      int gw, sw, sl, col;
      if (m_over) return;
      if (is_p2) begin m_g2++; gw = m_g2; end
      else       begin m_g1++; gw = m_g1; end
      if (gw < GPS) begin
         push_exp(is_p2 ? 2 : 1, gw);
         return;
      end
      if (is_p2) begin m_s2++; sw = m_s2; sl = m_s1; end
      else       begin m_s1++; sw = m_s1; sl = m_s2; end
      col = COLB + 2 * m_set;
      if (sw < STW) begin
         push_exp(is_p2 ? 4 : 3, (col << 24) | (sw << 16) | (m_g2 << 8) | m_g1);
         m_g1 = 0; m_g2 = 0; m_set++;
      end else begin
         push_exp(is_p2 ? 6 : 5, (col << 24) | (sl << 16) | (m_g2 << 8) | m_g1);
         m_over = 1'b1;
         m_win  = is_p2 ? 2 : 1;
      end
   endtask

   // Sequencer: accept a request two cycles after it appears, then stay busy.
   always @(negedge clk) begin
      if (rst) begin
         cmd_ready = 1'b1;
         seen      = 0;
         in_busy   = 1'b0;
      end else if (!in_busy) begin
         if (op != 4'd15) begin
            seen++;
            if (seen >= 2) begin
               log_op.push_back(op);
               log_data.push_back(data);
               cmd_ready = 1'b0;
               in_busy   = 1'b1;
               bcnt      = 0;
               seen      = 0;
            end
         end else begin
            seen = 0;
         end
      end else begin
         bcnt++;
         if (bcnt >= seq_busy && !seq_hold) begin
            cmd_ready = 1'b1;
            in_busy   = 1'b0;
         end
      end
   end

   logic [3:0]  prev_op   = 4'd15;
   logic [31:0] prev_data = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_op = 4'd15;
      end else begin
         if (op != 4'd15) begin
            if (prev_op == 4'd15) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_op: got op %0d data %0h, expected no request", op, data);
               end else begin
                  cur_t = exp_q.pop_front();
                  chk("cmd_op", 32'(op), 32'(cur_t.op));
                  chk("cmd_data", data, cur_t.data);
               end
            end else begin
               chk("op_stable", 32'(op), 32'(prev_op));
               chk("data_stable", data, prev_data);
            end
         end
         prev_op   = op;
         prev_data = data;
      end
   end

   task automatic pulse(input bit a, input bit b, input bit nm);
      @(negedge clk);
      p1_point = a; p2_point = b; new_match = nm;
      @(negedge clk);
      p1_point = 1'b0; p2_point = 1'b0; new_match = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0 || cmd_ready !== 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d, expected idle within 3000 cycles",
                  name, busy, exp_q.size());
      end
   endtask

   task automatic send_point(input bit is_p2, input string name);
      pulse(!is_p2, is_p2, 1'b0);
      model_point(is_p2);
      wait_idle(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_new_match();
      repeat (3) @(negedge clk);
      chk("rst_op", 32'(op), 32'd15);
      chk("rst_data", data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_match_over", 32'(match_over), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_drop", 32'(drop_sticky), 32'd0);
      rst = 1'b0;

      // Welcome op 0 with a long sequencer busy phase.
      wait_idle("init");
      chk("t1_op", 32'(op), 32'd15);
      chk("t1_busy", 32'(busy), 32'd0);
      chk_log("t1_cmd", 0, 4'd0, 32'd0);
      seq_busy = 3;

      // Single P1 point: op appears on the third edge after the pulse.
      @(negedge clk);
      p1_point = 1'b1;
      model_point(1'b0);
      @(negedge clk);
      p1_point = 1'b0;
      @(negedge clk);
      chk("t2_lat_none", 32'(op), 32'd15);
      @(negedge clk);
      chk("t2_lat_op", 32'(op), 32'd1);
      chk("t2_lat_data", data, 32'h00000001);
      wait_idle("t2");
      chk_log("t2_cmd", log_op.size() - 1, 4'd1, 32'h00000001);
      chk("t2_op_after", 32'(op), 32'd15);

      // Remaining games of set 0 for P1.
      for (int i = 0; i < 5; i++) send_point(1'b0, "t3");
      chk_log("t3_set", log_op.size() - 1, 4'd3, 32'h00010006);

      // P2 takes set 1 6-0, then P1 takes the final set 6-3.
      for (int i = 0; i < 6; i++) send_point(1'b1, "t4a");
      chk_log("t4_set2", log_op.size() - 1, 4'd4, 32'h02010600);
      for (int i = 0; i < 3; i++) send_point(1'b1, "t4b");
      for (int i = 0; i < 6; i++) send_point(1'b0, "t4c");
      chk_log("t4_match", log_op.size() - 1, 4'd5, 32'h04010306);
      chk("t4_winner", 32'(winner), 32'(m_win));
      chk("t4_match_over", 32'(match_over), 32'(m_over));
      chk("t4_busy", 32'(busy), 32'd0);

      base_n = log_op.size();
      pulse(1'b1, 1'b0, 1'b0);
      model_point(1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      model_point(1'b1);
      repeat (10) @(negedge clk);
      chk("t4_ignored_cnt", 32'(log_op.size()), 32'(base_n));
      chk("t4_ignored_drop", 32'(drop_sticky), 32'd0);
      chk("t4_still_over", 32'(match_over), 32'd1);

      // new_match from OVER re-sends the welcome op and clears the score.
      pulse(1'b0, 1'b0, 1'b1);
      model_new_match();
      wait_idle("t6b");
      chk_log("t6_reissue", log_op.size() - 1, 4'd0, 32'd0);
      chk("t6_match_over", 32'(match_over), 32'd0);
      chk("t6_winner", 32'(winner), 32'd0);

      // Sequencer stalls in its busy phase while five P2 points arrive.
      seq_hold = 1'b1;
      base_n = log_op.size();
      pulse(1'b1, 1'b0, 1'b0);
      model_point(1'b0);
      w = 0;
      while (log_op.size() <= base_n && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) begin
         checks++;
         errors++;
         $display("FAIL t5_accept_timeout: no command accepted, expected one within 200 cycles");
      end
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         pulse(1'b0, 1'b1, 1'b0);
         if (i < 4) model_point(1'b1);
      end
      chk("t5_op_held", 32'(op), 32'd15);
      chk("t5_drop", 32'(drop_sticky), 32'd1);
      chk("t5_busy", 32'(busy), 32'd1);
      seq_hold = 1'b0;
      wait_idle("t5");
      chk_log("t5_p1", base_n, 4'd1, 32'd1);
      for (int i = 0; i < 4; i++) chk_log("t5_p2", base_n + 1 + i, 4'd2, 32'(i + 1));
      chk("t5_cnt", 32'(log_op.size()), 32'(base_n + 5));

      // new_match together with a point: only the welcome op follows.
      base_n = log_op.size();
      pulse(1'b1, 1'b0, 1'b1);
      model_new_match();
      wait_idle("t6c");
      chk("t6_drop_clr", 32'(drop_sticky), 32'd0);
      chk_log("t6_nm_op", base_n, 4'd0, 32'd0);
      chk("t6_nm_cnt", 32'(log_op.size()), 32'(base_n + 1));

      // Simultaneous points: P1 kept, P2 dropped.
      pulse(1'b1, 1'b1, 1'b0);
      model_point(1'b0);
      wait_idle("t6a");
      chk_log("t6_simul", log_op.size() - 1, 4'd1, 32'd1);
      chk("t6_simul_drop", 32'(drop_sticky), 32'd1);
      chk("t6_simul_cnt", 32'(log_op.size()), 32'(base_n + 2));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
